// File: rtl/can_bit_timing.sv
// CAN bit-timing unit.
// Splits each bit into SYNC / TSEG1 / TSEG2 time quanta, driven by rising
// edges of the divided tq_clk sampled in the clk100Mhz domain. Pulses
// sample_point at the end of TSEG1 and tx_point at bit start, and re-aligns
// to recessive->dominant edges of rx by hard sync or SJW-limited resync.
module can_bit_timing #(
    parameter int unsigned TSEG1 = 7,   // PROP+PHASE1 quanta, 2..16
    parameter int unsigned TSEG2 = 2,   // PHASE2 quanta, 2..8
    parameter int unsigned SJW   = 1    // resync jump width, 1..4, <= TSEG2
) (
    input  logic       clk100Mhz,
    input  logic       reset,
    input  logic       tq_clk,
    input  logic       rx,
    input  logic       hard_sync_en,
    output logic       sample_point,
    output logic       sampled_bit,
    output logic       tx_point,
    output logic [1:0] seg
);

    localparam logic [1:0] SEG_SYNC  = 2'd0;
    localparam logic [1:0] SEG_TSEG1 = 2'd1;
    localparam logic [1:0] SEG_TSEG2 = 2'd2;

    localparam logic [4:0] TSEG1_C = 5'(TSEG1);
    localparam logic [4:0] TSEG2_C = 5'(TSEG2);
    localparam logic [4:0] SJW_CNT = 5'(SJW);
    localparam logic [2:0] SJW_C   = 3'(SJW);

    logic [1:0] seg_q, seg_d;
    logic [4:0] cnt_q, cnt_d;           // index of the quantum in progress within seg
    logic [2:0] ext_q, ext_d;           // TSEG1 lengthening from a late edge
    logic [2:0] shr_q, shr_d;           // TSEG2 shortening from an early edge
    logic       resync_done_q, resync_done_d;
    logic       tq_q;
    logic       rx_prev_q, rx_prev_d;
    logic       sample_point_q, sample_point_d;
    logic       tx_point_q, tx_point_d;
    logic       sampled_bit_q, sampled_bit_d;

    logic       tick;
    logic       rx_edge;
    logic [2:0] ext_eff;
    logic [2:0] shr_eff;
    logic       advance;

    assign tick    = tq_clk & ~tq_q;
    assign rx_edge = tick & rx_prev_q & ~rx;

    // Next-state: on each tick end the current quantum, applying sync rules first.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        seg_d          = seg_q;
        cnt_d          = cnt_q;
        ext_d          = ext_q;
        shr_d          = shr_q;
        resync_done_d  = resync_done_q;
        rx_prev_d      = rx_prev_q;
        sampled_bit_d  = sampled_bit_q;
        sample_point_d = 1'b0;
        tx_point_d     = 1'b0;
        ext_eff        = ext_q;
        shr_eff        = shr_q;
        advance        = 1'b1;

        if (tick) begin
            rx_prev_d = rx;
            if (rx_edge && hard_sync_en) begin
                // The quantum just ended is re-labelled SYNC; no tx_point.
                seg_d         = SEG_TSEG1;
                cnt_d         = 5'd1;
                ext_d         = 3'd0;
                shr_d         = 3'd0;
                resync_done_d = 1'b1;
            end else begin
                if (rx_edge && !resync_done_q) begin
                    resync_done_d = 1'b1;
                    case (seg_q)
                        SEG_TSEG1: ext_eff = (cnt_q < SJW_CNT) ? cnt_q[2:0] : SJW_C;
                        SEG_TSEG2: begin
                            // Phase error TSEG2-k+1 within SJW: the ended quantum was SYNC.
                            if (cnt_q + SJW_CNT > TSEG2_C) begin
                                seg_d      = SEG_TSEG1;
                                cnt_d      = 5'd1;
                                shr_eff    = 3'd0;
                                tx_point_d = 1'b1;
                                advance    = 1'b0;
                            end else begin
                                shr_eff = SJW_C;
                            end
                        end
                        default: ;
                    endcase
                end
                ext_d = ext_eff;
                shr_d = shr_eff;

                // Resync adjustments above are already visible to the end-of-segment checks.
                if (advance) begin
                    case (seg_q)
                        SEG_SYNC: begin
                            seg_d = SEG_TSEG1;
                            cnt_d = 5'd1;
                        end
                        SEG_TSEG1: begin
                            if (cnt_q >= TSEG1_C + {2'b00, ext_eff}) begin
                                seg_d          = SEG_TSEG2;
                                cnt_d          = 5'd1;
                                ext_d          = 3'd0;
                                resync_done_d  = 1'b0;
                                sample_point_d = 1'b1;
                                sampled_bit_d  = rx;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        SEG_TSEG2: begin
                            if (cnt_q >= TSEG2_C - {2'b00, shr_eff}) begin
                                seg_d      = SEG_SYNC;
                                cnt_d      = 5'd1;
                                shr_d      = 3'd0;
                                tx_point_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end
                        default: begin
                            seg_d = SEG_SYNC;
                            cnt_d = 5'd1;
                        end
                    endcase
                end
            end
        end
    end

    // State registers with synchronous reset; tq_q resets high so a held-high tq_clk gives no tick.
    always_ff @(posedge clk100Mhz) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            seg_q          <= SEG_SYNC;
            cnt_q          <= 5'd1;
            ext_q          <= 3'd0;
            shr_q          <= 3'd0;
            resync_done_q  <= 1'b0;
            tq_q           <= 1'b1;
            rx_prev_q      <= 1'b1;
            sample_point_q <= 1'b0;
            tx_point_q     <= 1'b0;
            sampled_bit_q  <= 1'b1;
        end else begin
            seg_q          <= seg_d;
            cnt_q          <= cnt_d;
            ext_q          <= ext_d;
            shr_q          <= shr_d;
            resync_done_q  <= resync_done_d;
            tq_q           <= tq_clk;
            rx_prev_q      <= rx_prev_d;
            sample_point_q <= sample_point_d;
            tx_point_q     <= tx_point_d;
            sampled_bit_q  <= sampled_bit_d;
        end
    end

    assign sample_point = sample_point_q;
    assign tx_point     = tx_point_q;
    assign sampled_bit  = sampled_bit_q;
    assign seg          = seg_q;

endmodule
